exu_shift_issue: RTL and testbench
==================================

# exu_shift_issue

Pipelined shift-issue stage between the IDU and the combinational `BarrelShifter` in the NPC execute path. It accepts decoded SLL/SRL/SRA/SLLI/SRLI/SRAI instructions over a valid/ready handshake and decodes the shift type and shift amount. It drives the shifter from registered operands and returns the result, tagged with `rd`, to writeback through a second valid/ready handshake. It also flags illegal shift encodings and counts retired shifts.

## Interface
- No parameters; datapath fixed at 32 bits, shamt at 5 bits.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: discard all in-flight entries (pipeline redirect).
- `in_valid` input 1 / `in_ready` output 1: IDU handshake.
- `in_opcode` input 7, `in_funct3` input 3, `in_funct7` input 7: instruction fields.
- `in_rs1_val` input 32, `in_rs2_val` input 32: register operands.
- `in_imm` input 12: I-type immediate.
- `in_rd` input 5: destination register.
- `sh_data` output 32, `sh_shamt` output 5, `sh_type` output 2: shifter operands. Type encoding is 00 SLL, 01 SRL, 10 SRA.
- `sh_result` input 32: combinational result returned from the shifter.
- `out_valid` output 1 / `out_ready` input 1: WBU handshake.
- `out_rd` output 5, `out_result` output 32, `out_illegal` output 1: writeback payload.
- `perf_shift_cnt` output 32: count of legal shifts retired.

## Operation
- **Decode, OP (0110011):**
  - funct3=001 and funct7=0000000 → SLL.
  - funct3=101 and funct7=0000000 → SRL.
  - funct3=101 and funct7=0100000 → SRA.
  - shamt = `in_rs2_val[4:0]`; upper rs2 bits are ignored.
- **Decode, OP-IMM (0010011):**
  - funct3=001 and imm[11:5]=0000000 → SLLI.
  - funct3=101 and imm[11:5]=0000000 → SRLI.
  - funct3=101 and imm[11:5]=0100000 → SRAI.
  - shamt = `in_imm[4:0]`.
- **Illegal encodings:** any other combination is illegal. Capture it with type=00, shamt=0 and illegal=1. `out_result` is forced to 0 for illegal entries.
- **S1 register:** holds valid, rd, rs1 value, type, shamt and illegal. It drives `sh_data`/`sh_type`/`sh_shamt` directly; all three are 0 when S1 is empty.
- **Input handshake:**
  - `in_ready = !flush && (!s1_valid || s1_advance)`.
  - An entry is accepted when `in_valid && in_ready`.
- **Output payload:** must stay stable while `out_valid && !out_ready`.
- **Counter:** `perf_shift_cnt` increments by 1 on each `out_valid && out_ready && !out_illegal`. It wraps from 0xFFFFFFFF to 0 and is not cleared by `flush`.
- **Flush:** clears every valid bit at the next edge. An input offered in the flush cycle is not accepted. An output handshake completing in the flush cycle still counts.
- **Reset:** returns all state to the values listed under Timing. Reset in the middle of a transfer discards the entry; no output is produced for it.

## Timing
- **Reset values:** `in_ready`=1 (asserts once `rst` deasserts). `out_valid`=0, `out_rd`=0, `out_result`=0, `out_illegal`=0, `sh_data`/`sh_shamt`/`sh_type`=0, `perf_shift_cnt`=0.
- **Default build:**
  - An entry accepted at edge N gives `out_valid` in cycle N+1.
  - `out_result = s1_illegal ? 0 : sh_result` (combinational through the shifter).
  - `s1_advance = !s1_valid || out_ready`.
- **Throughput:** 1 instruction/cycle with `out_ready` held high; there are no bubbles.
- **Backpressure:** with `out_ready`=0 and S1 full, `in_ready`=0 in that same cycle (combinational path `out_ready` → `in_ready`).
- **Simultaneous events:**
  - Same-cycle dequeue and enqueue replaces the S1 entry with no gap.
  - `flush` wins over any same-cycle enqueue.

## Configuration
- `SHIFT_RESULT_REG_EN`: defined adds output register S2 between the shifter and WBU.
  - S2 captures rd, illegal and the masked `sh_result`.
  - Latency becomes 2: accept at edge N → `out_valid` in cycle N+2.
  - S1 advances when S2 is empty or draining; S2 holds its payload under backpressure.
  - Full throughput is kept; `flush` clears S1 and S2.
- Undefined: single-stage behaviour as specified under Timing.

## Test plan
- **SLLI:** rs1=0x0000_0001, imm=0x01F, funct3=001 → `out_result`=0x8000_0000, illegal=0, `perf_shift_cnt`=1.
- **SRA and SRL:** rs1=0x8000_0000, rs2=0x0000_0104 (shamt 4).
  - funct7=0100000 → 0xF800_0000.
  - funct7=0000000 → 0x0800_0000.
- **Illegal:** OP funct3=001 funct7=0100000 → illegal=1, result=0x0000_0000, counter unchanged.
- **Backpressure:** 4 back-to-back SRLI with `out_ready` low for 3 cycles.
  - Results arrive in order, payload stable while stalled, `in_ready`=0 while full.
  - Zero-bubble stream resumes after `out_ready` rises.
- **Flush:** assert `flush` with S1 full and `in_valid` high → next cycle `out_valid`=0, that input was not accepted, next accepted entry proceeds normally.
- **Configuration and reset:** run both builds on the same stream with `rst` pulsed mid-stream → latency 1 vs 2, identical result sequence, all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/exu_shift_issue.sv
// Shift-issue stage: decodes SLL/SRL/SRA(+I) from the IDU, drives the external barrel shifter, returns rd+result to WBU.
// Latency: 1 cycle from accept to out_valid (2 cycles when SHIFT_RESULT_REG_EN is defined, adding output register S2).
// Backpressure: valid/ready on both sides; in_ready drops combinationally when the stage is full and out_ready is low.
//
// Ports: clk/rst (sync, active-high), flush (drop in-flight entries), IDU side in_* (valid/ready + instruction fields),
//        shifter side sh_data/sh_shamt/sh_type out, sh_result in, WBU side out_* (valid/ready + rd/result/illegal),
//        perf_shift_cnt (legal shifts retired, wraps, survives flush).
// Config macro: SHIFT_RESULT_REG_EN -- registers the masked shifter result in S2 before writeback.

module exu_shift_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [11:0] in_imm,
    input  logic [4:0]  in_rd,
    output logic [31:0] sh_data,
    output logic [4:0]  sh_shamt,
    output logic [1:0]  sh_type,
    input  logic [31:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_illegal,
    output logic [31:0] perf_shift_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [1:0] TYPE_SLL   = 2'b00;
    localparam logic [1:0] TYPE_SRL   = 2'b01;
    localparam logic [1:0] TYPE_SRA   = 2'b10;

    // Only the low 5 bits of rs2 form the shift amount.
    logic unused_rs2_hi;
    assign unused_rs2_hi = ^in_rs2_val[31:5];

    // ---------------- decode ----------------
    logic       is_op;
    logic       is_op_imm;
    logic [6:0] dec_hi;      // funct7 for OP, imm[11:5] for OP-IMM
    logic [1:0] dec_type;
    logic [4:0] dec_shamt;
    logic       dec_illegal;

    assign is_op     = (in_opcode == OPC_OP);
    assign is_op_imm = (in_opcode == OPC_OP_IMM);
    assign dec_hi    = is_op ? in_funct7 : in_imm[11:5];

    always_comb begin
        dec_type    = TYPE_SLL;
        dec_shamt   = 5'd0;
        dec_illegal = 1'b1;
        if (is_op || is_op_imm) begin
            if (in_funct3 == 3'b001 && dec_hi == 7'b0000000) begin
                dec_type    = TYPE_SLL;
                dec_illegal = 1'b0;
            end else if (in_funct3 == 3'b101 && dec_hi == 7'b0000000) begin
                dec_type    = TYPE_SRL;
                dec_illegal = 1'b0;
            end else if (in_funct3 == 3'b101 && dec_hi == 7'b0100000) begin
                dec_type    = TYPE_SRA;
                dec_illegal = 1'b0;
            end
        end
        // Illegal entries keep shamt at 0 so the shifter sees a benign request.
        if (!dec_illegal) begin
            dec_shamt = is_op ? in_rs2_val[4:0] : in_imm[4:0];
        end
    end

    // ---------------- S1 ----------------
    logic        s1_valid;
    logic [4:0]  s1_rd;
    logic [31:0] s1_data;
    logic [1:0]  s1_type;
    logic [4:0]  s1_shamt;
    logic        s1_illegal;
    logic        s1_advance;
    logic        accept;
    logic [31:0] s1_masked;

    assign in_ready = !flush && s1_advance;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_rd      <= 5'd0;
            s1_data    <= 32'd0;
            s1_type    <= TYPE_SLL;
            s1_shamt   <= 5'd0;
            s1_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_advance) begin
            // Dequeue and enqueue in the same cycle simply overwrite the entry.
            s1_valid <= accept;
            if (accept) begin
                s1_rd      <= in_rd;
                s1_data    <= in_rs1_val;
                s1_type    <= dec_type;
                s1_shamt   <= dec_shamt;
                s1_illegal <= dec_illegal;
            end
        end
    end

    assign sh_data   = s1_valid ? s1_data  : 32'd0;
    assign sh_type   = s1_valid ? s1_type  : TYPE_SLL;
    assign sh_shamt  = s1_valid ? s1_shamt : 5'd0;
    assign s1_masked = (s1_valid && !s1_illegal) ? sh_result : 32'd0;

`ifdef SHIFT_RESULT_REG_EN
    // ---------------- S2 (registered result) ----------------
    logic        s2_valid;
    logic [4:0]  s2_rd;
    logic [31:0] s2_result;
    logic        s2_illegal;
    logic        s2_advance;

    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_rd      <= 5'd0;
            s2_result  <= 32'd0;
            s2_illegal <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_advance) begin
            s2_valid   <= s1_valid;
            s2_rd      <= s1_rd;
            s2_result  <= s1_masked;
            s2_illegal <= s1_valid && s1_illegal;
        end
    end

    assign out_valid   = s2_valid;
    assign out_rd      = s2_valid ? s2_rd : 5'd0;
    assign out_result  = s2_valid ? s2_result : 32'd0;
    assign out_illegal = s2_valid && s2_illegal;
`else
    assign s1_advance  = !s1_valid || out_ready;
    assign out_valid   = s1_valid;
    assign out_rd      = s1_valid ? s1_rd : 5'd0;
    assign out_result  = s1_masked;
    assign out_illegal = s1_valid && s1_illegal;
`endif

    // ---------------- retire counter ----------------
    // Counts completed legal handshakes, including one landing in a flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_shift_cnt <= 32'd0;
        end else if (out_valid && out_ready && !out_illegal) begin
            perf_shift_cnt <= perf_shift_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_exu_shift_issue.sv
// Testbench for exu_shift_issue: random and directed instruction streams checked by a scoreboard.
// Latency expectation follows SHIFT_RESULT_REG_EN (1 or 2 cycles).
// Backpressure driven through out_ready; flush and reset pulses discard scoreboard entries.

module tb_exu_shift_issue;

`ifdef SHIFT_RESULT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [6:0]  in_opcode, in_funct7;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1_val, in_rs2_val, sh_data, sh_result, out_result, perf_shift_cnt;
    logic [11:0] in_imm;
    logic [4:0]  in_rd, sh_shamt, out_rd;
    logic [1:0]  sh_type;

    always #5 clk = ~clk;

    exu_shift_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
        .sh_data(sh_data), .sh_shamt(sh_shamt), .sh_type(sh_type), .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_result(out_result), .out_illegal(out_illegal),
        .perf_shift_cnt(perf_shift_cnt)
    );

    // Environment: behaves like the combinational barrel shifter.
    always_comb begin
        case (sh_type)
            2'b00:   sh_result = sh_data << sh_shamt;
            2'b01:   sh_result = sh_data >> sh_shamt;
            2'b10:   sh_result = $unsigned($signed(sh_data) >>> sh_shamt);
            default: sh_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   last_hs = -100;
    bit   presented = 0;
    int   model_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: architectural meaning of the instruction, plain arithmetic.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [11:0] imm, input logic [4:0] rd);
        exp_t m;
        logic [6:0] hi;
        int sh;
        hi    = (opc == OP) ? f7 : imm[11:5];
        sh    = (opc == OP) ? int'(rs2 % 32) : int'(imm % 32);
        m.rd  = rd;
        m.ill = 1'b1;
        m.res = 32'd0;
        m.acc = 0;
        if (opc == OP || opc == OPI) begin
            if (f3 == 3'd1 && hi == 7'd0) begin
                m.ill = 1'b0;
                m.res = rs1 << sh;
            end else if (f3 == 3'd5 && hi == 7'd0) begin
                m.ill = 1'b0;
                m.res = rs1 >> sh;
            end else if (f3 == 3'd5 && hi == 7'h20) begin
                m.ill = 1'b0;
                // Arithmetic shift: logical shift plus sign fill of the vacated top bits.
                m.res = (rs1 >> sh) | (rs1[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            end
        end
        return m;
    endfunction

    // Stimulus side of the scoreboard: record every accepted instruction.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_t e;
            e = model(in_opcode, in_funct3, in_funct7, in_rs1_val, in_rs2_val, in_imm, in_rd);
            e.acc = cyc;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every presented output against the queue head.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            presented = 0;
            last_hs   = -100;
        end else begin
            chk("perf_cnt", perf_shift_cnt, model_cnt);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: got rd=%0d result=%h, expected no output", out_rd, out_result);
                end else begin
                    exp_t e;
                    int   due;
                    e = exp_q[0];
                    if (!presented) begin
                        due = (e.acc + LAT > last_hs + 1) ? e.acc + LAT : last_hs + 1;
                        chk("latency_cycle", cyc, due);
                        presented = 1;
                    end
                    chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("out_result", out_result, e.res);
                    chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        presented = 0;
                        last_hs   = cyc;
                        if (!e.ill) model_cnt++;
                    end
                end
            end
            if (flush) begin
                exp_q.delete();
                presented = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until accepted; returns at posedge+1 after the accept edge.
    task automatic send(input logic [4:0] rd, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [11:0] imm);
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_rd = rd; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
        in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
        sync();
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [4:0] rd);
        logic [6:0] opc, hi, f7;
        logic [2:0] f3;
        logic [11:0] imm;
        int r;
        r   = $urandom_range(0, 7);
        opc = (r < 4) ? OP : (r < 7) ? OPI : 7'($urandom);
        f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5);
        r   = $urandom_range(0, 4);
        hi  = (r < 2) ? 7'h00 : (r < 4) ? 7'h20 : 7'($urandom);
        f7  = (opc == OP) ? hi : 7'($urandom);
        imm = {((opc == OPI) ? hi : 7'($urandom)), 5'($urandom)};
        send(rd, opc, f3, f7, $urandom, $urandom, imm);
    endtask

    // Wait (bounded) for the next output at a negedge and compare it with fixed values.
    task automatic expect_out(input string name, input logic [4:0] rd, input logic [31:0] res, input logic ill);
        for (int i = 0; i < 10; i++) begin
            if (i > 0 || !out_valid) @(negedge clk);
            if (out_valid) break;
        end
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        chk({name, "_result"}, out_result, res);
        chk({name, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
        sync();
    endtask

    task automatic check_sh(input string name, input logic [31:0] d, input logic [4:0] s, input logic [1:0] t);
        chk({name, "_sh_data"}, sh_data, d);
        chk({name, "_sh_shamt"}, {27'd0, sh_shamt}, {27'd0, s});
        chk({name, "_sh_type"}, {30'd0, sh_type}, {30'd0, t});
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_out_rd", {27'd0, out_rd}, 32'd0);
        chk("idle_out_result", out_result, 32'd0);
        chk("idle_out_illegal", {31'd0, out_illegal}, 32'd0);
        check_sh("idle", 32'd0, 5'd0, 2'd0);
        chk("idle_perf", perf_shift_cnt, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, {31'd0, !flush});
    endtask

    bit done;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rs1_val = '0; in_rs2_val = '0;
        in_imm = '0; in_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle();
        sync();

        // SLLI by 31 with garbage in funct7 (ignored for OP-IMM).
        send(5'd1, OPI, 3'b001, 7'h55, 32'h0000_0001, 32'hFFFF_FFFF, 12'h01F);
        check_sh("slli", 32'h0000_0001, 5'd31, 2'b00);
        expect_out("slli", 5'd1, 32'h8000_0000, 1'b0);
        @(negedge clk);
        chk("slli_perf", perf_shift_cnt, 32'd1);
        sync();

        send(5'd2, OP, 3'b101, 7'h20, 32'h8000_0000, 32'h0000_0104, 12'h000);
        check_sh("sra", 32'h8000_0000, 5'd4, 2'b10);
        expect_out("sra", 5'd2, 32'hF800_0000, 1'b0);
        send(5'd3, OP, 3'b101, 7'h00, 32'h8000_0000, 32'h0000_0104, 12'h000);
        check_sh("srl", 32'h8000_0000, 5'd4, 2'b01);
        expect_out("srl", 5'd3, 32'h0800_0000, 1'b0);

        send(5'd4, OP, 3'b001, 7'h20, 32'hFFFF_FFFF, 32'h0000_0003, 12'h000);
        check_sh("illegal", 32'hFFFF_FFFF, 5'd0, 2'b00);
        expect_out("illegal", 5'd4, 32'h0000_0000, 1'b1);
        @(negedge clk);
        chk("illegal_perf", perf_shift_cnt, 32'd3);
        sync();

        // Backpressure: four back-to-back SRLI, out_ready low for three cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(5'(10 + i), OPI, 3'b101, 7'h00, $urandom, 32'd0, 12'(i + 1));
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
                chk("bp_rd_held", {27'd0, out_rd}, 32'd10);
                sync();
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);
                end
            end
        join
        repeat (3) sync();

        // Flush with S1 occupied and a new input offered in the same cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd20; in_opcode = OPI; in_funct3 = 3'b101; in_funct7 = 7'h00;
        in_rs1_val = 32'h1234_5678; in_rs2_val = 32'd0; in_imm = 12'h004;
        sync();
        in_rd = 5'd21;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        sync();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        sync();
        send(5'd22, OPI, 3'b001, 7'h00, 32'h0000_00F0, 32'd0, 12'h004);
        expect_out("post_flush", 5'd22, 32'h0000_0F00, 1'b0);

        // Random stream with random backpressure, sporadic flushes, and a reset mid-stream.
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if (i == 150) begin
                        rst = 1'b1;
                        in_valid = 1'b0;
                        sync();
                        rst = 1'b0;
                        check_idle();
                        sync();
                    end
                    send_rand(5'($urandom));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    sync();
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush     = ($urandom_range(0, 40) == 0);
                end
                out_ready = 1'b1;
                flush     = 1'b0;
            end
        join

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) sync();
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
